// File: rtl/zx8x_tape_player_if.sv
// Control and tape-buffer signals of the ZX80/ZX81 cassette playback engine.
// The master side is the host plus the tape buffer RAM; the slave side is the player.
interface zx8x_tape_player_if;
   logic        start;
   logic        stop;
   logic        pause;
   logic        zx81;
   logic [13:0] len;
   logic [13:0] rd_addr;
   logic [7:0]  rd_data;
   logic        tape_out;
   logic        busy;
   logic        done;

   modport master (
      output start, stop, pause, zx81, len, rd_data,
      input  rd_addr, tape_out, busy, done
   );

   modport slave (
      input  start, stop, pause, zx81, len, rd_data,
      output rd_addr, tape_out, busy, done
   );
endinterface

// File: rtl/zx8x_tape_player.sv
// Real-time ZX80/ZX81 cassette playback: regenerates the ROM SAVE waveform
// (pulse bursts per bit, silence gaps) from a tape image held in a registered RAM.
module zx8x_tape_player #(
   parameter int unsigned PULSE_HI_CYC = 7800,
   parameter int unsigned PULSE_LO_CYC = 7800,
   parameter int unsigned GAP_CYC      = 67600,
   parameter int unsigned LEADER_CYC   = 26000000,
   parameter int unsigned CNT_W        = 25
) (
   input logic               clk_sys,
   input logic               reset,
   zx8x_tape_player_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle, StLeader, StFetch, StLatch, StPulseH, StPulseL, StGap, StFinish
   } state_e;

   localparam logic [CNT_W-1:0] HiLoad     = CNT_W'(PULSE_HI_CYC - 1);
   localparam logic [CNT_W-1:0] LoLoad     = CNT_W'(PULSE_LO_CYC - 1);
   localparam logic [CNT_W-1:0] GapLoad    = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] LeaderLoad = CNT_W'(LEADER_CYC - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [13:0]      idx_q, idx_d;
   logic [13:0]      len_q, len_d;
   logic [13:0]      rd_addr_q, rd_addr_d;
   logic             zx81_q, zx81_d;
   logic             name_sent_q, name_sent_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [2:0]       bit_q, bit_d;
   logic [3:0]       pulse_q, pulse_d;
   logic             byte_sel;
   logic             cnt_zero;

   assign cnt_zero = (cnt_q == '0);

   // Next-state logic: stop beats pause, pause freezes everything.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      len_d       = len_q;
      rd_addr_d   = rd_addr_q;
      zx81_d      = zx81_q;
      name_sent_d = name_sent_q;
      shreg_d     = shreg_q;
      bit_d       = bit_q;
      pulse_d     = pulse_q;
      byte_sel    = 1'b0;

      if (bus.stop) begin
         state_d = StIdle;
      end else if (!bus.pause) begin
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  zx81_d      = bus.zx81;
                  len_d       = bus.len;
                  idx_d       = '0;
                  name_sent_d = 1'b0;
                  cnt_d       = LeaderLoad;
                  state_d     = StLeader;
               end
            end
            StLeader: begin
               if (cnt_zero) byte_sel = 1'b1;
               else          cnt_d    = cnt_q - 1'b1;
            end
            StFetch: begin
               state_d = StLatch;
            end
            StLatch: begin
               shreg_d = bus.rd_data;
               idx_d   = idx_q + 14'd1;
               bit_d   = 3'd7;
               pulse_d = bus.rd_data[7] ? 4'd9 : 4'd4;
               cnt_d   = HiLoad;
               state_d = StPulseH;
            end
            StPulseH: begin
               if (cnt_zero) begin
                  cnt_d   = LoLoad;
                  state_d = StPulseL;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            StPulseL: begin
               if (!cnt_zero) begin
                  cnt_d = cnt_q - 1'b1;
               end else if (pulse_q > 4'd1) begin
                  pulse_d = pulse_q - 4'd1;
                  cnt_d   = HiLoad;
                  state_d = StPulseH;
               end else begin
                  cnt_d   = GapLoad;
                  state_d = StGap;
               end
            end
            StGap: begin
               if (!cnt_zero) begin
                  cnt_d = cnt_q - 1'b1;
               end else if (bit_q != 3'd0) begin
                  bit_d   = bit_q - 3'd1;
                  shreg_d = {shreg_q[6:0], 1'b0};
                  pulse_d = shreg_q[6] ? 4'd9 : 4'd4;
                  cnt_d   = HiLoad;
                  state_d = StPulseH;
               end else begin
                  byte_sel = 1'b1;
               end
            end
            StFinish: begin
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase

         // Next-byte selection: synthetic name byte first, then buffer bytes.
         if (byte_sel) begin
            if (zx81_q && !name_sent_q) begin
               shreg_d     = 8'h80;
               name_sent_d = 1'b1;
               bit_d       = 3'd7;
               pulse_d     = 4'd9;
               cnt_d       = HiLoad;
               state_d     = StPulseH;
            end else if (idx_q < len_q) begin
               // Address is presented on entry to FETCH so the registered RAM
               // returns the byte in LATCH.
               rd_addr_d = idx_q;
               state_d   = StFetch;
            end else begin
               state_d = StFinish;
            end
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         idx_q       <= '0;
         len_q       <= '0;
         rd_addr_q   <= '0;
         zx81_q      <= 1'b0;
         name_sent_q <= 1'b0;
         shreg_q     <= '0;
         bit_q       <= '0;
         pulse_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         len_q       <= len_d;
         rd_addr_q   <= rd_addr_d;
         zx81_q      <= zx81_d;
         name_sent_q <= name_sent_d;
         shreg_q     <= shreg_d;
         bit_q       <= bit_d;
         pulse_q     <= pulse_d;
      end
   end

   assign bus.tape_out = (state_q == StPulseH);
   assign bus.busy     = (state_q != StIdle);
   // Held off while paused or stopped so the strobe fires exactly once, never on abort.
   assign bus.done     = (state_q == StFinish) && !bus.pause && !bus.stop;
   assign bus.rd_addr  = rd_addr_q;

endmodule
